// File: rtl/booth_mul_arbiter.sv
// Round-robin front end sharing one signed 8x8 radix-4 Booth multiplier among
// NREQ requesters; operands are registered, the product returns tagged with its source.

module boothmultiplier (
  input  logic signed [7:0]  a,
  input  logic signed [7:0]  b,
  output logic signed [15:0] c
);
  logic signed [15:0] a_ext;
  logic signed [15:0] pp;
  logic signed [15:0] acc;
  logic        [8:0]  b_ext;
  logic        [2:0]  grp;

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    a_ext = {{8{a[7]}}, a};
    b_ext = {b, 1'b0};
    acc   = '0;
    pp    = '0;
    grp   = '0;
    // Each 3-bit window of the multiplier selects 0, +-a or +-2a, weighted by 4^j.
    for (int j = 0; j < 4; j++) begin
      grp = b_ext[2*j+2 -: 3];
      case (grp)
        3'b001, 3'b010: pp = a_ext;
        3'b011:         pp = a_ext <<< 1;
        3'b100:         pp = -(a_ext <<< 1);
        3'b101, 3'b110: pp = -a_ext;
        default:        pp = '0;
      endcase
      acc = acc + (pp <<< (2*j));
    end
    c = acc;
  end
endmodule

module booth_mul_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*8-1:0]   req_a,
  input  logic [NREQ*8-1:0]   req_b,
  output logic [NREQ-1:0]     req_ready,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [IDW-1:0]      resp_id,
  output logic [15:0]         resp_p,
  output logic                busy
);
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_RESP} state_t;

  state_t             state, state_d;
  logic [IDW-1:0]     rr_ptr;
  logic [IDW-1:0]     cur_id;
  logic signed [7:0]  op_a, op_b;
  logic signed [15:0] res_p;
  logic signed [15:0] mult_c;

  logic               grant_found;
  logic [IDW-1:0]     grant_id;
  logic [7:0]         win_a, win_b;

  boothmultiplier u_mult (
    .a (op_a),
    .b (op_b),
    .c (mult_c)
  );

  // Two passes: indices at or above the pointer first, then the wrapped-around lower ones.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_found && req_valid[i] && (IDW'(i) >= rr_ptr)) begin
        grant_found = 1'b1;
        grant_id    = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_found && req_valid[i] && (IDW'(i) < rr_ptr)) begin
        grant_found = 1'b1;
        grant_id    = IDW'(i);
      end
    end
  end

  always_comb begin
    win_a = '0;
    win_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == grant_id) begin
        win_a = req_a[8*i +: 8];
        win_b = req_b[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d   = state;
    req_ready = '0;
    case (state)
      S_IDLE: begin
        if (grant_found) begin
          // Gated by rst_n so no grant is shown while reset is held.
          req_ready = NREQ'(rst_n) << grant_id;
          state_d   = S_CALC;
        end
      end
      S_CALC:  state_d = S_RESP;
      S_RESP:  if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      rr_ptr <= '0;
      cur_id <= '0;
      op_a   <= '0;
      op_b   <= '0;
      res_p  <= '0;
    end else begin
      state <= state_d;
      if (state == S_IDLE && grant_found) begin
        op_a   <= win_a;
        op_b   <= win_b;
        cur_id <= grant_id;
        rr_ptr <= (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + 1'b1;
      end
      if (state == S_CALC)
        res_p <= mult_c;
    end
  end

  assign resp_valid = (state == S_RESP);
  assign resp_p     = res_p;
  assign resp_id    = cur_id;
  assign busy       = (state != S_IDLE);
endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed bench for booth_mul_arbiter: reset, round-robin order, boundary products,
// backpressure, reset during CALC and a requester withdrawing before grant.

module tb_booth_mul_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*8-1:0] req_a;
  logic [NREQ*8-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              resp_valid;
  logic              resp_ready;
  logic [IDW-1:0]    resp_id;
  logic [15:0]       resp_p;
  logic              busy;

  int n_cmp = 0;
  int n_err = 0;

  booth_mul_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_p     (resp_p),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int idx, input logic [7:0] a, input logic [7:0] b);
    req_a[8*idx +: 8] = a;
    req_b[8*idx +: 8] = b;
  endtask

  // Assumes IDLE with stimulus applied and resp_ready=1; ends in the next IDLE cycle.
  task automatic do_txn(input int id, input logic [15:0] p);
    #1;
    check("grant", 16'(req_ready), 16'(1 << id));
    tick();
    check("calc_busy", 16'(busy), 16'd1);
    check("calc_ready", 16'(req_ready), 16'd0);
    check("calc_resp_valid", 16'(resp_valid), 16'd0);
    tick();
    check("resp_valid", 16'(resp_valid), 16'd1);
    check("resp_p", resp_p, p);
    check("resp_id", 16'(resp_id), 16'(id));
    tick();
    check("after_resp_valid", 16'(resp_valid), 16'd0);
    check("after_resp_busy", 16'(busy), 16'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_req_ready", 16'(req_ready), 16'd0);
    check("rst_resp_valid", 16'(resp_valid), 16'd0);
    check("rst_resp_p", resp_p, 16'd0);
    check("rst_resp_id", 16'(resp_id), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b1;

    // Reset state, including a valid request that must not be shown a grant.
    #2;
    req_valid = 4'b0001;
    #1;
    check_reset_outputs();
    req_valid = '0;
    tick();
    tick();
    rst_n = 1'b1;

    // (-16)x(-16) from requester 0.
    set_op(0, 8'hF0, 8'hF0);
    req_valid = 4'b0001;
    #1;
    check("first_grant_same_cycle", 16'(req_ready), 16'b0001);
    tick();
    req_valid = '0;
    #1;
    check("first_calc_resp_valid", 16'(resp_valid), 16'd0);
    check("first_calc_busy", 16'(busy), 16'd1);
    tick();
    check("first_resp_valid", 16'(resp_valid), 16'd1);
    check("first_resp_p", resp_p, 16'd256);
    check("first_resp_id", 16'(resp_id), 16'd0);
    tick();
    check("first_done", 16'(resp_valid), 16'd0);

    // Fresh reset so rr_ptr starts at 0 for the round-robin sweep.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < NREQ; i++) set_op(i, 8'(i + 1), 8'hFD);
    req_valid = 4'b1111;
    do_txn(0, 16'hFFFD);
    do_txn(1, 16'hFFFA);
    do_txn(2, 16'hFFF7);
    do_txn(3, 16'hFFF4);
    do_txn(0, 16'hFFFD);
    req_valid = '0;

    // Boundary products through requester 2; others carry ignored junk.
    set_op(0, 8'h55, 8'h55);
    set_op(1, 8'hAA, 8'hAA);
    set_op(3, 8'h33, 8'h77);
    req_valid = 4'b0100;
    set_op(2, 8'h80, 8'h80);
    do_txn(2, 16'h4000);
    set_op(2, 8'h80, 8'h7F);
    do_txn(2, 16'hC080);
    set_op(2, 8'h07, 8'h00);
    do_txn(2, 16'h0000);
    set_op(2, 8'h95, 8'h20);
    do_txn(2, 16'hF2A0);
    req_valid = '0;

    // Backpressure: rr_ptr=3, req 0 wins over req 1, which stays pending.
    resp_ready = 1'b0;
    set_op(0, 8'd3, 8'd5);
    set_op(1, 8'hFE, 8'd9);
    req_valid = 4'b0011;
    #1;
    check("bp_grant0", 16'(req_ready), 16'b0001);
    tick();
    req_valid = 4'b0010;
    #1;
    check("bp_calc_ready", 16'(req_ready), 16'd0);
    tick();
    for (int k = 0; k < 5; k++) begin
      check("bp_resp_valid", 16'(resp_valid), 16'd1);
      check("bp_resp_p", resp_p, 16'd15);
      check("bp_resp_id", 16'(resp_id), 16'd0);
      check("bp_ready_low", 16'(req_ready), 16'd0);
      tick();
    end
    resp_ready = 1'b1;
    #1;
    check("bp_release_valid", 16'(resp_valid), 16'd1);
    check("bp_release_p", resp_p, 16'd15);
    tick();
    check("bp_idle_resp_valid", 16'(resp_valid), 16'd0);
    do_txn(1, 16'hFFEE);
    req_valid = '0;

    // Reset during CALC drops the op; rr_ptr must return to 0.
    set_op(0, 8'd1, 8'd1);
    req_valid = 4'b0001;
    #1;
    check("rc_grant", 16'(req_ready), 16'b0001);
    tick();
    check("rc_in_calc", 16'(busy), 16'd1);
    rst_n     = 1'b0;
    req_valid = 4'b0100;
    #1;
    check_reset_outputs();
    tick();
    check_reset_outputs();
    req_valid = '0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rc_no_resp", 16'(resp_valid), 16'd0);
      check("rc_idle", 16'(busy), 16'd0);
    end
    set_op(0, 8'd10, 8'hF6);
    set_op(2, 8'hFB, 8'hFA);
    req_valid = 4'b0101;
    do_txn(0, 16'hFF9C);
    do_txn(2, 16'h001E);
    req_valid = '0;

    // Requester 3 withdraws while the arbiter serves requester 1.
    set_op(0, 8'd4, 8'd4);
    req_valid = 4'b0001;
    do_txn(0, 16'd16);
    set_op(1, 8'd6, 8'hF9);
    set_op(3, 8'd9, 8'd9);
    req_valid = 4'b1010;
    #1;
    check("wd_grant1", 16'(req_ready), 16'b0010);
    tick();
    req_valid = 4'b1000;
    tick();
    check("wd_resp_p", resp_p, 16'hFFD6);
    check("wd_resp_id", 16'(resp_id), 16'd1);
    req_valid = '0;
    tick();
    check("wd_no_grant", 16'(req_ready), 16'd0);
    for (int k = 0; k < 3; k++) begin
      check("wd_idle_busy", 16'(busy), 16'd0);
      check("wd_no_resp", 16'(resp_valid), 16'd0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
